// File: rtl/lmsm_sequencer.sv
// Load-Multiple / Store-Multiple sequencer: walks an 8-bit register mask lowest index first,
// moving each selected register to/from consecutive memory words starting at a base address.
module lmsm_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [NREG-1:0]           reg_mask,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      busy,
    output logic                      done,
    output logic [3:0]                xfer_cnt,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ack,
    output logic [$clog2(NREG)-1:0]   rf_radd,
    input  logic [DATA_W-1:0]         rf_rdata,
    output logic                      rf_wen,
    output logic [$clog2(NREG)-1:0]   rf_wadd,
    output logic [DATA_W-1:0]         rf_wdata
);

    localparam int IDX_W = $clog2(NREG);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        RDREG = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state;
    logic [NREG-1:0]     mask_q;
    logic [ADDR_W-1:0]   base_q;
    logic                store_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   data_q;
    logic [IDX_W-1:0]    low_idx;

    // Descending scan so the lowest set bit is the last one to win.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = NREG; i > 0; i--) begin
            if (mask_q[i-1]) begin
                low_idx = IDX_W'(i - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mask_q   <= '0;
            base_q   <= '0;
            store_q  <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
            xfer_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            rf_wen   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q   <= reg_mask;
                        base_q   <= base_addr;
                        store_q  <= is_store;
                        xfer_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (mask_q == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx_q           <= low_idx;
                        mask_q[low_idx] <= 1'b0;
                        if (store_q) begin
                            state <= RDREG;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            state   <= MEM;
                        end
                    end
                end
                RDREG: begin
                    data_q  <= rf_rdata;
                    mem_req <= 1'b1;
                    mem_we  <= 1'b1;
                    state   <= MEM;
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (store_q) begin
                            xfer_cnt <= xfer_cnt + 4'd1;
                            state    <= SCAN;
                        end else begin
                            data_q <= mem_rdata;
                            rf_wen <= 1'b1;
                            state  <= WB;
                        end
                    end
                end
                WB: begin
                    rf_wen   <= 1'b0;
                    xfer_cnt <= xfer_cnt + 4'd1;
                    state    <= SCAN;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Address is derived from the live count so it advances exactly once per completed transfer.
    assign mem_addr  = base_q + ADDR_W'(xfer_cnt);
    assign mem_wdata = data_q;
    assign rf_wdata  = data_q;
    assign rf_radd   = idx_q;
    assign rf_wadd   = idx_q;

endmodule
